// File: rtl/qmac_pipe.sv
// qmac_pipe: pipelined sign-magnitude fixed-point multiply-accumulate unit.
//
// The unit takes one operand pair per cycle. It multiplies the two
// magnitudes, rounds or truncates each product to Q fractional bits, and
// saturates it to an N-bit sign-magnitude term. Terms are summed in a signed
// N+G-bit accumulator. On the term marked i_last it emits one saturated
// N-bit sign-magnitude result, a sticky overflow flag and the term count.
//
// Pipeline: operand register -> product register (P1) -> term register (P2)
// -> accumulator/output. A last pair accepted at edge k shows up on o_valid
// after edge k+3.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_valid, o_ready   operand handshake; o_ready = !(o_valid && !i_ready)
//   i_multiplicand     sign-magnitude operand A (N bits)
//   i_multiplier       sign-magnitude operand B (N bits)
//   i_last             marks the final term of a vector
//   o_valid, i_ready   result handshake; the result is held until accepted
//   o_result           saturated sign-magnitude dot product (N bits)
//   o_ovr              sticky flag: saturation somewhere in this vector
//   o_count            number of terms in the vector, saturating at 65535
module qmac_pipe #(
  parameter int N     = 32,
  parameter int Q     = 24,
  parameter int G     = 8,
  parameter bit ROUND = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_last,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic [15:0]  o_count
);

  localparam int W  = N + G;
  localparam int MW = 2 * N - 2;

  localparam logic [MW:0]          RND_ADD      = ROUND ? ({{MW{1'b0}}, 1'b1} << (Q - 1)) : '0;
  localparam logic [N-2:0]         MAX_MAG      = '1;
  localparam logic [MW:0]          MAX_MAG_WIDE = {{(MW + 2 - N){1'b0}}, MAX_MAG};
  localparam logic [W-1:0]         OUT_MAX      = {{(G + 1){1'b0}}, MAX_MAG};
  localparam logic signed [W-1:0]  ACC_MAX      = {1'b0, {(W - 1){1'b1}}};
  localparam logic signed [W:0]    SUM_MAX      = {2'b00, {(W - 1){1'b1}}};
  localparam logic signed [W:0]    SUM_MIN      = -SUM_MAX;

  logic w_stall;
  logic w_accept;

  // Operand register
  logic         r_s0_valid;
  logic [N-1:0] r_s0_a;
  logic [N-1:0] r_s0_b;
  logic         r_s0_last;

  // P1: product register
  logic [MW-1:0] w_p1_mag;
  logic          w_p1_sign;
  logic          r_p1_valid;
  logic [MW-1:0] r_p1_mag;
  logic          r_p1_sign;
  logic          r_p1_last;

  // P2: scaled, saturated, signed term register
  logic [MW:0]          w_rounded;
  logic [MW:0]          w_scaled;
  logic                 w_term_ovr;
  logic [N-2:0]         w_term_mag;
  logic [W-1:0]         w_term_ext;
  logic [W-1:0]         w_term;
  logic                 r_p2_valid;
  logic signed [W-1:0]  r_p2_term;
  logic                 r_p2_ovr;
  logic                 r_p2_last;

  // Accumulator and output
  logic signed [W-1:0]  r_acc;
  logic                 r_first;
  logic                 r_vec_ovr;
  logic [15:0]          r_cnt;
  logic signed [W-1:0]  w_base;
  logic signed [W:0]    w_sum;
  logic                 w_acc_ovr;
  logic [W-1:0]         w_acc_next;
  logic [W-1:0]         w_abs;
  logic                 w_out_ovr;
  logic [N-2:0]         w_out_mag;
  logic [15:0]          w_cnt_base;
  logic [15:0]          w_cnt_next;
  logic                 w_vec_next;
  logic                 r_out_valid;
  logic [N-1:0]         r_out_result;
  logic                 r_out_ovr;
  logic [15:0]          r_out_count;

  assign w_stall  = r_out_valid && !i_ready;
  assign o_ready  = !w_stall;
  assign w_accept = i_valid && o_ready;

  // A zero product is always positive so that -0 operands give +0.
  assign w_p1_mag  = {{(N - 1){1'b0}}, r_s0_a[N-2:0]} * {{(N - 1){1'b0}}, r_s0_b[N-2:0]};
  assign w_p1_sign = (r_s0_a[N-1] ^ r_s0_b[N-1]) && (w_p1_mag != '0);

  // One spare bit on the rounding add keeps the carry out of the top.
  assign w_rounded  = {1'b0, r_p1_mag} + RND_ADD;
  assign w_scaled   = w_rounded >> Q;
  assign w_term_ovr = w_scaled > MAX_MAG_WIDE;
  assign w_term_mag = w_term_ovr ? MAX_MAG : w_scaled[N-2:0];
  assign w_term_ext = {{(G + 1){1'b0}}, w_term_mag};
  assign w_term     = r_p1_sign ? -w_term_ext : w_term_ext;

  // The sum is formed one bit wider so signed overflow is a plain range test.
  // The range is symmetric, so the most negative code also counts as overflow.
  assign w_base     = r_first ? '0 : r_acc;
  assign w_sum      = {w_base[W-1], w_base} + {r_p2_term[W-1], r_p2_term};
  assign w_acc_ovr  = (w_sum > SUM_MAX) || (w_sum < SUM_MIN);
  assign w_acc_next = w_acc_ovr ? (w_sum[W] ? -ACC_MAX : ACC_MAX) : w_sum[W-1:0];
  assign w_abs      = w_acc_next[W-1] ? -w_acc_next : w_acc_next;
  assign w_out_ovr  = w_abs > OUT_MAX;
  assign w_out_mag  = w_out_ovr ? MAX_MAG : w_abs[N-2:0];
  assign w_cnt_base = r_first ? 16'd0 : r_cnt;
  assign w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + 16'd1;
  assign w_vec_next = (r_first ? 1'b0 : r_vec_ovr) | r_p2_ovr | w_acc_ovr;

  // Front pipeline: everything freezes while the output is stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0_valid <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_last  <= 1'b0;
      r_p1_valid <= 1'b0;
      r_p1_mag   <= '0;
      r_p1_sign  <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p2_valid <= 1'b0;
      r_p2_term  <= '0;
      r_p2_ovr   <= 1'b0;
      r_p2_last  <= 1'b0;
    end else if (!w_stall) begin
      r_s0_valid <= w_accept;
      if (w_accept) begin
        r_s0_a    <= i_multiplicand;
        r_s0_b    <= i_multiplier;
        r_s0_last <= i_last;
      end
      r_p1_valid <= r_s0_valid;
      r_p1_mag   <= w_p1_mag;
      r_p1_sign  <= w_p1_sign;
      r_p1_last  <= r_s0_last;
      r_p2_valid <= r_p1_valid;
      r_p2_term  <= w_term;
      r_p2_ovr   <= w_term_ovr;
      r_p2_last  <= r_p1_last;
    end
  end

  // Accumulator and output register. When not stalled any held result is
  // being accepted this edge, so o_valid follows "a last term arrives".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc        <= '0;
      r_first      <= 1'b1;
      r_vec_ovr    <= 1'b0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovr    <= 1'b0;
      r_out_count  <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_p2_valid && r_p2_last;
      if (r_p2_valid) begin
        if (r_p2_last) begin
          r_acc        <= '0;
          r_first      <= 1'b1;
          r_vec_ovr    <= 1'b0;
          r_cnt        <= '0;
          r_out_result <= {w_acc_next[W-1], w_out_mag};
          r_out_ovr    <= w_vec_next | w_out_ovr;
          r_out_count  <= w_cnt_next;
        end else begin
          r_acc     <= w_acc_next;
          r_first   <= 1'b0;
          r_vec_ovr <= w_vec_next;
          r_cnt     <= w_cnt_next;
        end
      end
    end
  end

  assign o_valid  = r_out_valid;
  assign o_result = r_out_result;
  assign o_ovr    = r_out_ovr;
  assign o_count  = r_out_count;

endmodule

// File: tb/tb_qmac_pipe.sv
// tb_qmac_pipe: self-checking bench for qmac_pipe with N=8, Q=5, G=8.
// Two instances share all inputs: one rounds (ROUND=1), one truncates.
// A vector-level model produces each expected result when the last pair of
// a vector is accepted; one compare process checks the outputs every cycle.
module tb_qmac_pipe;

  localparam int N = 8;
  localparam int Q = 5;
  localparam int G = 8;
  localparam int HALF_LSB = 1 << (Q - 1);
  localparam int MAG_MAX  = (1 << (N - 1)) - 1;
  localparam int ACC_LIM  = (1 << (N + G - 1)) - 1;

  typedef struct {
    logic [7:0]  res1;
    logic        ovr1;
    logic [7:0]  res0;
    logic        ovr0;
    logic [15:0] cnt;
    bit          hasLit;
    logic [7:0]  litRes;
    logic        litOvr;
    logic [15:0] litCnt;
    bit          hasLit0;
    logic [7:0]  litRes0;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iValid = 1'b0;
  logic        iLast = 1'b0;
  logic        iReady = 1'b1;
  logic [7:0]  iA = '0;
  logic [7:0]  iB = '0;
  logic        rdy1, val1, ovr1, rdy0, val0, ovr0;
  logic [7:0]  res1, res0;
  logic [15:0] cnt1, cnt0;

  int errors = 0;
  int checks = 0;
  int stallSamples = 0;
  bit stallArm = 1'b0;

  logic [7:0] curA[$];
  logic [7:0] curB[$];
  expT        expQ[$];

  always #5 clk = ~clk;

  qmac_pipe #(.N(N), .Q(Q), .G(G), .ROUND(1'b1)) dutRound (
    .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(rdy1),
    .i_multiplicand(iA), .i_multiplier(iB), .i_last(iLast),
    .o_valid(val1), .i_ready(iReady), .o_result(res1), .o_ovr(ovr1), .o_count(cnt1)
  );

  qmac_pipe #(.N(N), .Q(Q), .G(G), .ROUND(1'b0)) dutTrunc (
    .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(rdy0),
    .i_multiplicand(iA), .i_multiplier(iB), .i_last(iLast),
    .o_valid(val0), .i_ready(iReady), .o_result(res0), .o_ovr(ovr0), .o_count(cnt0)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Dot product of the buffered vector using plain integer arithmetic.
  // Returns {overflow, sign, magnitude}.
  function automatic logic [8:0] modelVec(input bit rnd);
    int acc = 0;
    bit ov = 1'b0;
    int m, sc, mag;
    for (int i = 0; i < curA.size(); i++) begin
      m  = int'(curA[i][6:0]) * int'(curB[i][6:0]);
      sc = (m + (rnd ? HALF_LSB : 0)) >> Q;
      if (sc > MAG_MAX) begin
        sc = MAG_MAX;
        ov = 1'b1;
      end
      if ((curA[i][7] ^ curB[i][7]) && m != 0) sc = -sc;
      acc += sc;
      if (acc > ACC_LIM) begin
        acc = ACC_LIM;
        ov  = 1'b1;
      end else if (acc < -ACC_LIM) begin
        acc = -ACC_LIM;
        ov  = 1'b1;
      end
    end
    mag = (acc < 0) ? -acc : acc;
    if (mag > MAG_MAX) begin
      mag = MAG_MAX;
      ov  = 1'b1;
    end
    return {ov, (acc < 0), 7'(mag)};
  endfunction

  // Offer one pair and wait for it to be accepted; leaves i_valid high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last,
                               input bit hasLit, input logic [7:0] litRes, input logic litOvr,
                               input logic [15:0] litCnt, input bit hasLit0, input logic [7:0] litRes0);
    bit done = 1'b0;
    logic [8:0] m1, m0;
    expT e;
    @(negedge clk);
    iValid = 1'b1;
    iA = a;
    iB = b;
    iLast = last;
    for (int t = 0; t < 50 && !done; t++) begin
      #3;
      if (rdy1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    curA.push_back(a);
    curB.push_back(b);
    if (last) begin
      m1 = modelVec(1'b1);
      m0 = modelVec(1'b0);
      e.res1 = m1[7:0];
      e.ovr1 = m1[8];
      e.res0 = m0[7:0];
      e.ovr0 = m0[8];
      e.cnt = 16'(curA.size());
      e.hasLit = hasLit;
      e.litRes = litRes;
      e.litOvr = litOvr;
      e.litCnt = litCnt;
      e.hasLit0 = hasLit0;
      e.litRes0 = litRes0;
      expQ.push_back(e);
      curA.delete();
      curB.delete();
    end
  endtask

  task automatic idle();
    @(negedge clk);
    iValid = 1'b0;
    iLast = 1'b0;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 60 && expQ.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("drained", 32'(expQ.size()), 32'd0);
    checkOutput("idle_valid", 32'(val1), 32'd0);
  endtask

  // Downstream: when armed, refuse the first result for five cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (stallArm && val1) begin
        iReady = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        iReady = 1'b1;
        stallArm = 1'b0;
      end
    end
  end

  // Compare process, sampling just before each rising edge.
  initial begin
    bit prevStall = 1'b0;
    bit stall;
    logic [7:0]  pRes;
    logic        pOvr;
    logic [15:0] pCnt;
    expT e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        checkOutput("o_ready", 32'(rdy1), 32'(!(val1 && !iReady)));
        checkOutput("valid_pair", 32'(val0), 32'(val1));
        if (prevStall) begin
          checkOutput("hold_valid", 32'(val1), 32'd1);
          checkOutput("hold_result", 32'(res1), 32'(pRes));
          checkOutput("hold_ovr", 32'(ovr1), 32'(pOvr));
          checkOutput("hold_count", 32'(cnt1), 32'(pCnt));
        end
        stall = val1 && !iReady;
        if (stall) begin
          stallSamples++;
          pRes = res1;
          pOvr = ovr1;
          pCnt = cnt1;
        end
        if (val1 && iReady) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 32'(res1), 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("result", 32'(res1), 32'(e.res1));
            checkOutput("ovr", 32'(ovr1), 32'(e.ovr1));
            checkOutput("count", 32'(cnt1), 32'(e.cnt));
            checkOutput("trunc_result", 32'(res0), 32'(e.res0));
            checkOutput("trunc_ovr", 32'(ovr0), 32'(e.ovr0));
            if (e.hasLit) begin
              checkOutput("lit_result", 32'(res1), 32'(e.litRes));
              checkOutput("lit_ovr", 32'(ovr1), 32'(e.litOvr));
              checkOutput("lit_count", 32'(cnt1), 32'(e.litCnt));
            end
            if (e.hasLit0) checkOutput("lit_trunc_result", 32'(res0), 32'(e.litRes0));
          end
        end
        prevStall = stall;
      end
    end
  end

  initial begin
    // Reset values
    #12;
    checkOutput("rst_valid", 32'(val1), 32'd0);
    checkOutput("rst_result", 32'(res1), 32'd0);
    checkOutput("rst_ovr", 32'(ovr1), 32'd0);
    checkOutput("rst_count", 32'(cnt1), 32'd0);
    checkOutput("rst_ready", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic dot product with latency check
    applyStimulus(8'h20, 8'h30, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'hA0, 8'h10, 1'b1, 1, 8'h20, 1'b0, 16'd2, 0, 0);
    @(negedge clk);
    iValid = 1'b0;
    iLast = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("latency_edge%0d", j), 32'(val1), 32'(j == 3));
    end
    waitDrain();

    // Rounding versus truncation
    applyStimulus(8'h01, 8'h10, 1'b1, 1, 8'h01, 1'b0, 16'd1, 1, 8'h00);
    idle();
    waitDrain();

    // Term saturation and sticky flag
    applyStimulus(8'h7F, 8'h7F, 1'b1, 1, 8'h7F, 1'b1, 16'd1, 0, 0);
    applyStimulus(8'h7F, 8'h7F, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'hA0, 8'h20, 1'b1, 1, 8'h5F, 1'b1, 16'd2, 0, 0);
    idle();
    waitDrain();

    // Negative zero and sign
    applyStimulus(8'h80, 8'h05, 1'b1, 1, 8'h00, 1'b0, 16'd1, 0, 0);
    applyStimulus(8'h90, 8'h20, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'h08, 8'h20, 1'b1, 1, 8'h88, 1'b0, 16'd2, 0, 0);
    idle();
    waitDrain();

    // Backpressure: three back-to-back vectors, first result refused 5 cycles
    stallSamples = 0;
    stallArm = 1'b1;
    applyStimulus(8'h20, 8'h20, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'h20, 8'h10, 1'b1, 1, 8'h30, 1'b0, 16'd2, 0, 0);
    applyStimulus(8'hA0, 8'h20, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'h08, 8'h20, 1'b1, 1, 8'h98, 1'b0, 16'd2, 0, 0);
    applyStimulus(8'h30, 8'h30, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'h81, 8'h20, 1'b1, 1, 8'h47, 1'b0, 16'd2, 0, 0);
    idle();
    waitDrain();
    checkOutput("stall_cycles", 32'(stallSamples), 32'd5);

    // Reset mid-vector
    applyStimulus(8'h20, 8'h20, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8'h20, 8'h20, 1'b0, 0, 0, 0, 0, 0, 0);
    #1;
    iValid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(val1), 32'd0);
    checkOutput("midrst_result", 32'(res1), 32'd0);
    checkOutput("midrst_ovr", 32'(ovr1), 32'd0);
    checkOutput("midrst_count", 32'(cnt1), 32'd0);
    checkOutput("midrst_ready", 32'(rdy1), 32'd1);
    #1;
    rst = 1'b0;
    curA.delete();
    curB.delete();
    applyStimulus(8'h20, 8'h20, 1'b1, 1, 8'h20, 1'b0, 16'd1, 0, 0);
    idle();
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
